// File: rtl/serial_sub_ctrl.sv
// Bit-serial WIDTH-bit subtractor: one full-subtractor cell plus a borrow flop,
// LSB first, with start/busy/done handshake. diff = a - b - bin mod 2^WIDTH.
module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_sh, b_sh, r_sh;
  logic             brw, brw_nx, d_bit;
  logic             a_msb, b_msb;
  logic [CW-1:0]    cnt;
  logic             last;

  // Full-subtractor bit cell on the current LSBs
  always_comb begin
    d_bit  = a_sh[0] ^ b_sh[0] ^ brw;
    brw_nx = (~a_sh[0] & b_sh[0]) | (~a_sh[0] & brw) | (b_sh[0] & brw);
    last   = (cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = SHIFT;
      SHIFT:   if (last)  state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh       <= '0;
      b_sh       <= '0;
      r_sh       <= '0;
      brw        <= 1'b0;
      a_msb      <= 1'b0;
      b_msb      <= 1'b0;
      cnt        <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            brw   <= bin;
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
            cnt   <= '0;
          end
        end
        SHIFT: begin
          r_sh <= {d_bit, r_sh[WIDTH-1:1]};
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          brw  <= brw_nx;
          cnt  <= cnt + CW'(1);
          // Result registers load straight from the final cell output so the
          // published diff never shows a partial value.
          if (last) begin
            diff       <= {d_bit, r_sh[WIDTH-1:1]};
            borrow_out <= brw_nx;
            ovf        <= (a_msb ^ b_msb) & (d_bit ^ a_msb);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Self-checking bench for serial_sub_ctrl: directed cases plus random operands,
// compared against an integer-arithmetic reference model.
module tb_serial_sub_ctrl;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a, b;
  logic             bin;
  logic             busy, done, borrow_out, ovf;
  logic [WIDTH-1:0] diff;

  int total = 0;
  int bad   = 0;

  logic [WIDTH-1:0] prev_diff;
  logic             prev_bo, prev_ovf;

  serial_sub_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .diff(diff), .borrow_out(borrow_out), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain signed/unsigned integer arithmetic
  task automatic model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb, input logic mbi,
                       output logic [WIDTH-1:0] d, output logic bo, output logic ov);
    int ur, sr, sa, sb;
    ur = int'(ma) - int'(mb) - int'(mbi);
    d  = WIDTH'(ur);
    bo = (ur < 0);
    sa = int'(ma) - ((ma[WIDTH-1]) ? (1 << WIDTH) : 0);
    sb = int'(mb) - ((mb[WIDTH-1]) ? (1 << WIDTH) : 0);
    sr = sa - sb - int'(mbi);
    ov = (sr > (1 << (WIDTH-1)) - 1) || (sr < -(1 << (WIDTH-1)));
  endtask

  // One complete operation; poke injects an ignored start(0xFF-0x01) on busy cycle 3
  task automatic run_op(input logic [WIDTH-1:0] oa, input logic [WIDTH-1:0] ob,
                        input logic obi, input bit poke);
    logic [WIDTH-1:0] ed;
    logic eb, eo;
    model(oa, ob, obi, ed, eb, eo);
    @(negedge clk);
    a = oa; b = ob; bin = obi; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      chk("busy_hi", busy, 1);
      chk("done_lo_busy", done, 0);
      chk("diff_stable", diff, prev_diff);
      if (poke && i == 2) begin
        start = 1'b1; a = 8'hFF; b = 8'h01; bin = 1'b0;
      end else begin
        start = 1'($urandom_range(0, 1));
        a = WIDTH'($urandom); b = WIDTH'($urandom); bin = 1'($urandom);
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk("done_hi", done, 1);
    chk("busy_lo_done", busy, 0);
    chk("diff", diff, ed);
    chk("borrow_out", borrow_out, eb);
    chk("ovf", ovf, eo);
    prev_diff = ed; prev_bo = eb; prev_ovf = eo;
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("busy_idle", busy, 0);
    chk("diff_hold", diff, ed);
  endtask

  logic [WIDTH-1:0] dir_a [5] = '{8'h35, 8'h12, 8'h00, 8'h80, 8'h7F};
  logic [WIDTH-1:0] dir_b [5] = '{8'h12, 8'h35, 8'h00, 8'h01, 8'hFF};
  logic             dir_i [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

  initial begin
    int done_t[$];
    int ndone;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    prev_diff = '0; prev_bo = 1'b0; prev_ovf = 1'b0;

    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_diff", diff, 0);
    chk("rst_bo", borrow_out, 0);
    chk("rst_ovf", ovf, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < 5; k++) run_op(dir_a[k], dir_b[k], dir_i[k], 1'b0);

    // Ignored start mid-operation; the 0x35-0x12 result must still appear
    run_op(8'h35, 8'h12, 1'b0, 1'b1);
    chk("poke_result", diff, 8'h23);

    // bin=1 with a==b
    run_op(8'h5A, 8'h5A, 1'b1, 1'b0);
    chk("aeqb_bin_diff", diff, 8'hFF);
    chk("aeqb_bin_bo", borrow_out, 1);

    // start held high: done every WIDTH+2 cycles
    @(negedge clk);
    a = 8'h35; b = 8'h12; bin = 1'b0; start = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done) begin
        done_t.push_back(c);
        chk("cont_diff", diff, 8'h23);
      end
    end
    start = 1'b0;
    chk("cont_count", done_t.size(), 4);
    for (int i = 1; i < done_t.size(); i++)
      chk("cont_period", done_t[i] - done_t[i-1], WIDTH + 2);
    repeat (12) @(negedge clk);
    prev_diff = 8'h23; prev_bo = 1'b0; prev_ovf = 1'b0;

    // Reset during bit 4
    @(negedge clk);
    a = 8'h12; b = 8'h35; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_diff", diff, 0);
    chk("mid_rst_bo", borrow_out, 0);
    chk("mid_rst_ovf", ovf, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    chk("no_done_after_rst", ndone, 0);
    prev_diff = '0; prev_bo = 1'b0; prev_ovf = 1'b0;
    run_op(8'h35, 8'h12, 1'b0, 1'b0);
    chk("post_rst_result", diff, 8'h23);

    for (int k = 0; k < 30; k++)
      run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
